// File: rtl/key_code_checker_if.sv
// Keypad link, password and verdict bundle between the keyboard,
// the code checker and the main alarm FSM.
interface key_code_checker_if #(
  parameter int DIGITS = 4
) ();
  localparam int CW = $clog2(DIGITS + 1);

  logic [1:0]          KB_IN;
  logic                KB_RECV;
  logic [2*DIGITS-1:0] VALID_KEY;
  logic [1:0]          KEY_STATUS;
  logic [CW-1:0]       DIGIT_COUNT;
  logic                BUSY;

  modport master (
    output KB_IN,
    output KB_RECV,
    output VALID_KEY,
    input  KEY_STATUS,
    input  DIGIT_COUNT,
    input  BUSY
  );

  modport slave (
    input  KB_IN,
    input  KB_RECV,
    input  VALID_KEY,
    output KEY_STATUS,
    output DIGIT_COUNT,
    output BUSY
  );
endinterface

// File: rtl/key_code_checker.sv
// Assembles keypad digits into a code, compares it with the password
// and holds an OK/ERROR verdict for the main alarm FSM.
module key_code_checker #(
  parameter int DIGITS         = 4,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic             SERCLK_OUT,
  input  logic             RESET_IN,
  key_code_checker_if.slave kc
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;

  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] H_END    = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          mis_q, mis_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    status_q, status_d;
  logic          busy_q, busy_d;

  logic [1:0] kb_s1, kb_s2;
  logic       recv_s1, recv_s2, recv_s3;
  logic       dig_ev;
  logic       dig_mis;
  logic       last;
  logic [1:0] exp_dig;

  always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
    if (RESET_IN) begin
      kb_s1   <= '0;
      kb_s2   <= '0;
      recv_s1 <= 1'b0;
      recv_s2 <= 1'b0;
      recv_s3 <= 1'b0;
    end else begin
      kb_s1   <= kc.KB_IN;
      kb_s2   <= kb_s1;
      recv_s1 <= kc.KB_RECV;
      recv_s2 <= recv_s1;
      recv_s3 <= recv_s2;
    end
  end

  assign dig_ev = recv_s2 & ~recv_s3;
  assign last   = (dcnt_q == LAST_IDX);

  // Expected digit for the current index; first digit is the top pair.
  always_comb begin
    exp_dig = kc.VALID_KEY[2*DIGITS-1 -: 2];
    for (int i = 0; i < DIGITS; i++) begin
      if (dcnt_q == CW'(i))
        exp_dig = kc.VALID_KEY[2*(DIGITS-i)-1 -: 2];
    end
  end

  assign dig_mis = (kb_s2 != exp_dig);

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    mis_d    = mis_q;
    tcnt_d   = tcnt_q;
    hold_d   = hold_q;
    status_d = status_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        status_d = NO_KEY;
        busy_d   = 1'b0;
        tcnt_d   = '0;
        hold_d   = '0;
        if (dig_ev) begin
          dcnt_d  = dcnt_q + 1'b1;
          mis_d   = mis_q | dig_mis;
          busy_d  = 1'b1;
          state_d = last ? RESULT : COLLECT;
        end
      end
      COLLECT: begin
        if (dig_ev) begin
          dcnt_d  = dcnt_q + 1'b1;
          mis_d   = mis_q | dig_mis;
          tcnt_d  = '0;
          state_d = last ? RESULT : COLLECT;
        end else if (tcnt_q == T_LAST) begin
          // Abandoned partial code: drop it without a verdict.
          state_d  = IDLE;
          dcnt_d   = '0;
          mis_d    = 1'b0;
          tcnt_d   = '0;
          busy_d   = 1'b0;
          status_d = NO_KEY;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (hold_q != H_END) begin
          status_d = mis_q ? KEY_ERROR : KEY_OK;
          hold_d   = hold_q + 1'b1;
        end else begin
          state_d  = IDLE;
          status_d = NO_KEY;
          dcnt_d   = '0;
          mis_d    = 1'b0;
          hold_d   = '0;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      mis_q    <= 1'b0;
      tcnt_q   <= '0;
      hold_q   <= '0;
      status_q <= NO_KEY;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      mis_q    <= mis_d;
      tcnt_q   <= tcnt_d;
      hold_q   <= hold_d;
      status_q <= status_d;
      busy_q   <= busy_d;
    end
  end

  assign kc.KEY_STATUS  = status_q;
  assign kc.DIGIT_COUNT = dcnt_q;
  assign kc.BUSY        = busy_q;
endmodule
